// File: rtl/cache_pkg.sv
// Shared L1 cache types: tag-store entry layout and tag bank FSM states.
// With TAG_BANK_PARITY_EN defined, each entry carries an even-parity bit.
package cache_pkg;

    localparam int TAG_W_DEFAULT = 20;

    typedef struct packed {
`ifdef TAG_BANK_PARITY_EN
        logic                     parity;
`endif
        logic                     valid;
        logic [TAG_W_DEFAULT-1:0] tag;
    } tag_entry_t;

    typedef enum logic {
        FLUSH = 1'b0,
        IDLE  = 1'b1
    } tag_bank_state_t;

endpackage

// File: rtl/tag_way_ram.sv
// One way of the tag store: LINES x WIDTH simple dual-port RAM with a registered,
// read-first read port (the tag bank supplies write-first bypass itself).
module tag_way_ram #(
    parameter int LINES = 512,
    parameter int WIDTH = 21,
    parameter int AW    = $clog2(LINES)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [LINES];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/tag_bank_ways.sv
// Set-associative tag store with registered hit/way lookup, update port and
// invalidation sweep. Optional entry parity checking under TAG_BANK_PARITY_EN.
module tag_bank_ways
    import cache_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int LINES = 512,
    parameter int TAG_W = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lookup_valid,
    input  logic [$clog2(LINES)-1:0] lookup_line,
    input  logic [TAG_W-1:0]         lookup_tag,
    output logic                     lookup_ready,
    output logic                     hit_valid,
    output logic                     hit,
    output logic [WAYS-1:0]          hit_way,
    input  logic                     update_en,
    input  logic [$clog2(LINES)-1:0] update_line,
    input  logic [WAYS-1:0]          update_way,
    input  logic [TAG_W-1:0]         update_tag,
    input  logic                     update_valid,
    input  logic                     flush_req,
    output logic                     flush_busy,
    output logic                     parity_err
);

    localparam int LW = $clog2(LINES);

    // Same layout as tag_entry_t, but sized by this instance's TAG_W.
    typedef struct packed {
`ifdef TAG_BANK_PARITY_EN
        logic             parity;
`endif
        logic             valid;
        logic [TAG_W-1:0] tag;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    tag_bank_state_t state_q, state_d;
    logic [LW-1:0]   cnt_q, cnt_d;

    logic            lkp_v_q;
    logic [TAG_W-1:0] lkp_tag_q;
    logic [WAYS-1:0] byp_q, byp_d;
    entry_t          byp_entry_q;
    entry_t          upd_entry;

    logic            accept;
    logic            upd_fire;
    logic            flushing;
    logic [ENTRY_W-1:0] rd_bits [WAYS];
    logic [WAYS-1:0] match;
    logic [WAYS-1:0] perr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            FLUSH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LW'(LINES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = FLUSH;
                cnt_d   = '0;
            end
        endcase
    end

    assign flushing     = (state_q == FLUSH);
    assign lookup_ready = (state_q == IDLE);
    assign flush_busy   = flushing;
    assign accept       = lookup_valid & lookup_ready;
    assign upd_fire     = update_en & ~flushing;

    always_comb begin
        upd_entry       = '0;
        upd_entry.valid = update_valid;
        upd_entry.tag   = update_tag;
`ifdef TAG_BANK_PARITY_EN
        upd_entry.parity = ^{update_valid, update_tag};
`endif
    end

    // Ways written this cycle to the line being looked up must bypass the RAM.
    assign byp_d = (upd_fire && (update_line == lookup_line)) ? update_way : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FLUSH;
            cnt_q       <= '0;
            lkp_v_q     <= 1'b0;
            lkp_tag_q   <= '0;
            byp_q       <= '0;
            byp_entry_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lkp_v_q     <= accept;
            lkp_tag_q   <= lookup_tag;
            byp_q       <= byp_d;
            byp_entry_q <= upd_entry;
        end
    end

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        logic          wr_en;
        logic [LW-1:0] wr_addr;
        entry_t        wr_data;
        entry_t        ent;

        assign wr_en   = flushing | (upd_fire & update_way[gi]);
        assign wr_addr = flushing ? cnt_q : update_line;
        assign wr_data = flushing ? entry_t'('0) : upd_entry;

        tag_way_ram #(
            .LINES (LINES),
            .WIDTH (ENTRY_W)
        ) u_ram (
            .clk     (clk),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_addr (lookup_line),
            .rd_data (rd_bits[gi])
        );

        assign ent       = byp_q[gi] ? byp_entry_q : entry_t'(rd_bits[gi]);
        assign match[gi] = ent.valid && (ent.tag == lkp_tag_q);
`ifdef TAG_BANK_PARITY_EN
        assign perr[gi]  = ^ent;
`else
        assign perr[gi]  = 1'b0;
`endif
    end

    assign hit_valid  = lkp_v_q;
    assign hit_way    = lkp_v_q ? (match & ~perr) : '0;
    assign hit        = |hit_way;
    assign parity_err = lkp_v_q & (|perr);

endmodule

// File: tb/tb_tag_bank_ways.sv
// Directed bench for tag_bank_ways: vector table for lookup/update/bypass plus
// hand-written flush, mid-sweep reset and (with TAG_BANK_PARITY_EN) parity sequences.
module tb_tag_bank_ways;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lookup_valid = 1'b0;
    logic [8:0]  lookup_line = '0;
    logic [19:0] lookup_tag = '0;
    logic        lookup_ready;
    logic        hit_valid;
    logic        hit;
    logic [3:0]  hit_way;
    logic        update_en = 1'b0;
    logic [8:0]  update_line = '0;
    logic [3:0]  update_way = '0;
    logic [19:0] update_tag = '0;
    logic        update_valid = 1'b0;
    logic        flush_req = 1'b0;
    logic        flush_busy;
    logic        parity_err;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    tag_bank_ways #(.WAYS(4), .LINES(512), .TAG_W(20)) dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_valid (lookup_valid),
        .lookup_line  (lookup_line),
        .lookup_tag   (lookup_tag),
        .lookup_ready (lookup_ready),
        .hit_valid    (hit_valid),
        .hit          (hit),
        .hit_way      (hit_way),
        .update_en    (update_en),
        .update_line  (update_line),
        .update_way   (update_way),
        .update_tag   (update_tag),
        .update_valid (update_valid),
        .flush_req    (flush_req),
        .flush_busy   (flush_busy),
        .parity_err   (parity_err)
    );

    typedef struct {
        logic        ue;
        logic [8:0]  ul;
        logic [3:0]  uw;
        logic [19:0] ut;
        logic        uv;
        logic        le;
        logic [8:0]  ll;
        logic [19:0] lt;
        logic        exp_hv;
        logic        exp_hit;
        logic [3:0]  exp_way;
    } vec_t;

    function automatic vec_t mk(logic ue, logic [8:0] ul, logic [3:0] uw, logic [19:0] ut,
                                logic uv, logic le, logic [8:0] ll, logic [19:0] lt,
                                logic hv, logic h, logic [3:0] hw);
        vec_t v;
        v.ue = ue; v.ul = ul; v.uw = uw; v.ut = ut; v.uv = uv;
        v.le = le; v.ll = ll; v.lt = lt;
        v.exp_hv = hv; v.exp_hit = h; v.exp_way = hw;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " lookup_ready"}, 32'(lookup_ready), 32'd0);
        chk({tag, " flush_busy"},   32'(flush_busy),   32'd1);
        chk({tag, " hit_valid"},    32'(hit_valid),    32'd0);
        chk({tag, " hit"},          32'(hit),          32'd0);
        chk({tag, " hit_way"},      32'(hit_way),      32'd0);
        chk({tag, " parity_err"},   32'(parity_err),   32'd0);
    endtask

    // Called on a negedge; counts negedges with flush_busy=1, optionally
    // pulsing flush_req at sample 100 to confirm the sweep is not extended.
    task automatic count_sweep(input string tag, input bit poke_mid);
        int n = 0;
        int ready_bad = 0;
        while (flush_busy && n < 2000) begin
            if (lookup_ready) ready_bad++;
            flush_req = (poke_mid && n == 100);
            n++;
            @(negedge clk);
        end
        flush_req = 1'b0;
        chk({tag, " sweep length"}, 32'(n), 32'd512);
        chk({tag, " ready during sweep"}, 32'(ready_bad), 32'd0);
        chk({tag, " ready after sweep"}, 32'(lookup_ready), 32'd1);
        $display("sweep %s: busy for %0d cycles", tag, n);
    endtask

    task automatic do_lookup(input string tag, input logic [8:0] line, input logic [19:0] t,
                             input logic exp_hit, input logic [3:0] exp_way);
        lookup_valid = 1'b1;
        lookup_line  = line;
        lookup_tag   = t;
        @(negedge clk);
        lookup_valid = 1'b0;
        chk({tag, " hit_valid"}, 32'(hit_valid), 32'd1);
        chk({tag, " hit"},       32'(hit),       32'(exp_hit));
        chk({tag, " hit_way"},   32'(hit_way),   32'(exp_way));
        $display("lookup %s: line=%0d tag=%05h hv=%0b hit=%0b way=%b perr=%0b",
                 tag, line, t, hit_valid, hit, hit_way, parity_err);
    endtask

    always @(negedge clk) begin
        if (update_en && flush_busy) begin
            mismatched++;
            $display("FAIL update_during_flush: got update_en=1 expected 0 while busy");
        end
    end

    vec_t vecs[16];

    initial begin
        vecs[0]  = mk(0, 0,   4'b0000, 20'h0,     0, 1, 0, 20'h0,     1, 0, 4'b0000);
        vecs[1]  = mk(1, 5,   4'b0100, 20'h1ABCD, 1, 0, 0, 20'h0,     0, 0, 4'b0000);
        vecs[2]  = mk(0, 0,   4'b0000, 20'h0,     0, 1, 5, 20'h1ABCD, 1, 1, 4'b0100);
        vecs[3]  = mk(0, 0,   4'b0000, 20'h0,     0, 1, 5, 20'h1ABCE, 1, 0, 4'b0000);
        vecs[4]  = mk(1, 9,   4'b0001, 20'h00042, 1, 1, 9, 20'h00042, 1, 1, 4'b0001);
        vecs[5]  = mk(1, 9,   4'b0001, 20'h00042, 0, 1, 9, 20'h00042, 1, 0, 4'b0000);
        vecs[6]  = mk(0, 0,   4'b0000, 20'h0,     0, 1, 9, 20'h00042, 1, 0, 4'b0000);
        vecs[7]  = mk(1, 3,   4'b1111, 20'h00333, 1, 0, 0, 20'h0,     0, 0, 4'b0000);
        vecs[8]  = mk(0, 0,   4'b0000, 20'h0,     0, 1, 3, 20'h00333, 1, 1, 4'b1111);
        vecs[9]  = mk(1, 3,   4'b0000, 20'h00333, 0, 1, 3, 20'h00333, 1, 1, 4'b1111);
        vecs[10] = mk(1, 3,   4'b0010, 20'h00777, 1, 1, 3, 20'h00777, 1, 1, 4'b0010);
        vecs[11] = mk(0, 0,   4'b0000, 20'h0,     0, 1, 3, 20'h00333, 1, 1, 4'b1101);
        vecs[12] = mk(1, 3,   4'b0010, 20'h00333, 1, 1, 3, 20'h00333, 1, 1, 4'b1111);
        vecs[13] = mk(1, 4,   4'b0001, 20'h00333, 1, 1, 3, 20'h00333, 1, 1, 4'b1111);
        vecs[14] = mk(0, 0,   4'b0000, 20'h0,     0, 1, 4, 20'h00333, 1, 1, 4'b0001);
        vecs[15] = mk(0, 0,   4'b0000, 20'h0,     0, 1, 5, 20'h1ABCD, 1, 1, 4'b0100);

        // Power-on reset and first sweep.
        #1 rst = 1'b1;
        #1 chk_reset_values("por");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        count_sweep("por", 1'b0);

        // Vector table: inputs applied for one cycle, result checked next negedge.
        for (int i = 0; i < 16; i++) begin
            update_en    = vecs[i].ue;
            update_line  = vecs[i].ul;
            update_way   = vecs[i].uw;
            update_tag   = vecs[i].ut;
            update_valid = vecs[i].uv;
            lookup_valid = vecs[i].le;
            lookup_line  = vecs[i].ll;
            lookup_tag   = vecs[i].lt;
            @(negedge clk);
            update_en    = 1'b0;
            lookup_valid = 1'b0;
            chk($sformatf("vec%0d hit_valid", i), 32'(hit_valid), 32'(vecs[i].exp_hv));
            chk($sformatf("vec%0d hit", i),       32'(hit),       32'(vecs[i].exp_hit));
            chk($sformatf("vec%0d hit_way", i),   32'(hit_way),   32'(vecs[i].exp_way));
            chk($sformatf("vec%0d parity_err", i), 32'(parity_err), 32'd0);
            $display("vec %0d: upd=%0b line=%0d way=%b | lkp=%0b line=%0d tag=%05h -> hv=%0b hit=%0b way=%b",
                     i, vecs[i].ue, vecs[i].ul, vecs[i].uw, vecs[i].le, vecs[i].ll,
                     vecs[i].lt, hit_valid, hit, hit_way);
        end

        // Flush request together with a lookup of the fully populated line 3.
        flush_req    = 1'b1;
        lookup_valid = 1'b1;
        lookup_line  = 9'd3;
        lookup_tag   = 20'h00333;
        @(negedge clk);
        flush_req    = 1'b0;
        lookup_valid = 1'b0;
        chk("flush+lookup hit_valid", 32'(hit_valid), 32'd1);
        chk("flush+lookup hit_way",   32'(hit_way),   32'hF);
        $display("flush+lookup: hv=%0b hit=%0b way=%b busy=%0b", hit_valid, hit, hit_way, flush_busy);
        count_sweep("req", 1'b1);
        do_lookup("post-flush l3", 9'd3, 20'h00333, 1'b0, 4'b0000);

        // Reset asserted 100 cycles into a sweep.
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        repeat (100) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_values("midrst");
        @(negedge clk);
        rst = 1'b0;
        count_sweep("midrst", 1'b0);
        do_lookup("post-rst l4", 9'd4, 20'h00333, 1'b0, 4'b0000);

`ifdef TAG_BANK_PARITY_EN
        begin
            logic [21:0] word;
            update_en    = 1'b1;
            update_line  = 9'd7;
            update_way   = 4'b0010;
            update_tag   = 20'h0ABCD;
            update_valid = 1'b1;
            @(negedge clk);
            update_en = 1'b0;
            word = dut.g_way[1].u_ram.mem_q[7];
            word[21] = ~word[21];
            dut.g_way[1].u_ram.mem_q[7] = word;
            do_lookup("parity corrupt", 9'd7, 20'h0ABCD, 1'b0, 4'b0000);
            chk("parity corrupt parity_err", 32'(parity_err), 32'd1);
            do_lookup("parity clean", 9'd5, 20'h1ABCD, 1'b0, 4'b0000);
            chk("parity clean parity_err", 32'(parity_err), 32'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
